// File: rtl/flash_boot_loader.sv
`default_nettype none
// flash_boot_loader: copies a program image from SPI flash (READ 0x03, mode 0) into
// program RAM, holding the core in reset until the final byte has been written.
module flash_boot_loader #(
  parameter logic [23:0] FLASH_BASE  = 24'h020000,
  parameter int          LOAD_BYTES  = 32768,
  parameter int          ADDR_W      = 15,
  parameter int          CLK_DIV     = 2,
  parameter int          WAKE_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  output logic              FLASH_CS,
  output logic              FLASH_SCK,
  output logic              FLASH_MOSI,
  input  logic              FLASH_MISO,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              boot_done,
  output logic              core_rstn
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_GAP_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam logic [ADDR_W:0]    c_LAST_BYTE = (ADDR_W+1)'(LOAD_BYTES - 1);
  localparam logic [ADDR_W:0]    c_NUM_BYTES = (ADDR_W+1)'(LOAD_BYTES);
  localparam logic [31:0]        c_WAKE_WORD = {8'hAB, 24'h000000};
  localparam logic [31:0]        c_READ_WORD = {8'h03, FLASH_BASE};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAKE_CMD = 3'd1,
    S_WAKE_GAP = 3'd2,
    S_CMD      = 3'd3,
    S_DATA     = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                cs_q, cs_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                lead_q, lead_d;
  logic                tail_q, tail_d;
  logic [c_DIV_W-1:0]  div_q, div_d;
  logic [c_GAP_W-1:0]  gap_q, gap_d;
  logic [4:0]          bcnt_q, bcnt_d;
  logic [31:0]         sout_q, sout_d;
  logic [7:0]          sin_q, sin_d;
  logic                last_q, last_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W:0]     rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic                done_q, done_d;
  logic                win_end;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      lead_q      <= 1'b0;
      tail_q      <= 1'b0;
      div_q       <= '0;
      gap_q       <= '0;
      bcnt_q      <= '0;
      sout_q      <= '0;
      sin_q       <= '0;
      last_q      <= 1'b0;
      wr_pend_q   <= 1'b0;
      rx_cnt_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      lead_q      <= lead_d;
      tail_q      <= tail_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      bcnt_q      <= bcnt_d;
      sout_q      <= sout_d;
      sin_q       <= sin_d;
      last_q      <= last_d;
      wr_pend_q   <= wr_pend_d;
      rx_cnt_q    <= rx_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    lead_d      = lead_q;
    tail_d      = tail_q;
    div_d       = div_q;
    gap_d       = gap_q;
    bcnt_d      = bcnt_q;
    sout_d      = sout_q;
    sin_d       = sin_q;
    last_d      = last_q;
    wr_pend_d   = 1'b0;
    rx_cnt_d    = rx_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    done_d      = done_q;
    win_end     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b0;
        lead_d = 1'b1;
        div_d  = '0;
        bcnt_d = '0;
        if (WAKE_CYCLES > 0) begin
          state_d = S_WAKE_CMD;
          sout_d  = c_WAKE_WORD;
        end else begin
          state_d = S_CMD;
          sout_d  = c_READ_WORD;
        end
      end

      S_WAKE_GAP: begin
        if (gap_q == c_GAP_LAST) begin
          state_d = S_CMD;
          cs_d    = 1'b0;
          lead_d  = 1'b1;
          div_d   = '0;
          bcnt_d  = '0;
          sout_d  = c_READ_WORD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_WAKE_CMD, S_CMD, S_DATA: begin
        // lead: CS already low, SCK held low one CLK before the first bit
        // tail: SCK low one CLK after the last high phase, then CS released
        if (tail_q) begin
          tail_d  = 1'b0;
          cs_d    = 1'b1;
          gap_d   = '0;
          state_d = (state_q == S_WAKE_CMD) ? S_WAKE_GAP : S_DONE;
        end else if (lead_q) begin
          lead_d = 1'b0;
          mosi_d = sout_q[31];
          sout_d = {sout_q[30:0], 1'b0};
          div_d  = '0;
        end else if (!sck_q) begin
          if (div_q == c_DIV_LAST) begin
            sck_d = 1'b1;
            div_d = '0;
            sin_d = {sin_q[6:0], FLASH_MISO};
            if (state_q == S_DATA && bcnt_q[2:0] == 3'd7) begin
              wr_pend_d = 1'b1;
              last_d    = (rx_cnt_q == c_LAST_BYTE);
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end else begin
          if (div_q == c_DIV_LAST) begin
            sck_d   = 1'b0;
            div_d   = '0;
            win_end = (state_q == S_WAKE_CMD && bcnt_q == 5'd7) ||
                      (state_q == S_DATA && bcnt_q[2:0] == 3'd7 && last_q);
            if (win_end) begin
              tail_d = 1'b1;
              mosi_d = 1'b0;
            end else begin
              mosi_d = sout_q[31];
              sout_d = {sout_q[30:0], 1'b0};
              if (state_q == S_CMD && bcnt_q == 5'd31) begin
                state_d = S_DATA;
                bcnt_d  = '0;
              end else if (state_q == S_DATA) begin
                bcnt_d = {2'b00, bcnt_q[2:0] + 3'd1};
              end else begin
                bcnt_d = bcnt_q + 5'd1;
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        cs_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The byte completed on the sampling edge is committed one CLK later.
    if (wr_pend_q) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = rx_cnt_q[ADDR_W-1:0];
      ram_wdata_d = sin_q;
      rx_cnt_d    = rx_cnt_q + 1'b1;
    end
    if (ram_we_q && rx_cnt_q == c_NUM_BYTES) begin
      done_d = 1'b1;
    end
  end

  assign FLASH_CS   = cs_q;
  assign FLASH_SCK  = sck_q;
  assign FLASH_MOSI = mosi_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign boot_done  = done_q;
  assign core_rstn  = done_q;

endmodule
`default_nettype wire
